// File: rtl/reg_exchange_pkg.sv
// Shared definitions for the register exchange unit: command opcodes,
// FSM state encoding and the default data width.
// Optional build macro: SWAP_XOR_EN (XOR swap sequence, no temp registers).
package reg_exchange_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_LOAD_A = 2'b00,
        OP_LOAD_B = 2'b01,
        OP_SWAP   = 2'b10,
        OP_READ   = 2'b11
    } op_e;

    // ST_SW3 is only reachable when SWAP_XOR_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SW1  = 3'd1,
        ST_SW2  = 3'd2,
        ST_SW3  = 3'd3,
        ST_RESP = 3'd4
    } state_e;

endpackage

// File: rtl/reg_exchange_unit_if.sv
// Command and response channels of the register exchange unit.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command channel (requester -> unit)
//   rsp_valid/rsp_ready/rsp_a/rsp_b     : response channel (unit -> requester)
// master = requester side, slave = exchange unit side.
interface reg_exchange_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_a;
    logic [WIDTH-1:0] rsp_b;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_a, rsp_b
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_a, rsp_b
    );
endinterface

// File: rtl/reg_exchange_unit_swap_datapath.sv
// Holds operand registers A and B (plus temps in the default build) and
// applies the per-state updates requested by the FSM.
// Optional build macro: SWAP_XOR_EN (three-step XOR swap, temps removed).
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   state_i      : current FSM state
//   cmd_fire_i   : command accepted this cycle
//   op_i         : opcode of the command being accepted
//   data_i       : load operand
//   a_q_o, b_q_o : current A/B
//   a_d_o, b_d_o : A/B after this edge (used to capture the response)
module swap_datapath
    import reg_exchange_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  state_e           state_i,
    input  logic             cmd_fire_i,
    input  op_e              op_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] a_q_o,
    output logic [WIDTH-1:0] b_q_o,
    output logic [WIDTH-1:0] a_d_o,
    output logic [WIDTH-1:0] b_d_o
);
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
`ifndef SWAP_XOR_EN
    logic [WIDTH-1:0] temp_a_q, temp_a_d;
    logic [WIDTH-1:0] temp_b_q, temp_b_d;
`endif

    always_comb begin
        a_d = a_q;
        b_d = b_q;
`ifndef SWAP_XOR_EN
        temp_a_d = temp_a_q;
        temp_b_d = temp_b_q;
`endif
        if (cmd_fire_i && op_i == OP_LOAD_A) a_d = data_i;
        if (cmd_fire_i && op_i == OP_LOAD_B) b_d = data_i;
        case (state_i)
`ifdef SWAP_XOR_EN
            // Each step reads the values left by the previous one, so A==B
            // still ends up unchanged rather than cleared.
            ST_SW1: a_d = a_q ^ b_q;
            ST_SW2: b_d = a_q ^ b_q;
            ST_SW3: a_d = a_q ^ b_q;
`else
            ST_SW1: begin
                temp_a_d = a_q;
                temp_b_d = b_q;
            end
            ST_SW2: begin
                a_d = temp_b_q;
                b_d = temp_a_q;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
`ifndef SWAP_XOR_EN
            temp_a_q <= '0;
            temp_b_q <= '0;
`endif
        end else begin
            a_q <= a_d;
            b_q <= b_d;
`ifndef SWAP_XOR_EN
            temp_a_q <= temp_a_d;
            temp_b_q <= temp_b_d;
`endif
        end
    end

    assign a_q_o = a_q;
    assign b_q_o = b_q;
    assign a_d_o = a_d;
    assign b_d_o = b_d;
endmodule

// File: rtl/reg_exchange_unit.sv
// Command-driven two-register exchange engine. Accepts LOAD_A, LOAD_B,
// SWAP and READ commands one at a time and returns the post-command A/B
// values on the response channel; every accepted command yields exactly
// one response.
// Optional build macro: SWAP_XOR_EN (SWAP uses SW1..SW3 XOR sequence).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : command/response channels (slave modport)
//   busy  : high whenever the FSM is not idle
//
// state | meaning
// IDLE  | ready for a command
// SW1   | first swap step
// SW2   | second swap step (last step in default build)
// SW3   | third XOR swap step (SWAP_XOR_EN only)
// RESP  | response valid, waiting for rsp_ready
module reg_exchange_unit
    import reg_exchange_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_exchange_unit_if.slave  bus,
    output logic                busy
);
    state_e           state_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_a_q;
    logic [WIDTH-1:0] rsp_b_q;
    logic             cmd_fire;
    op_e              op;
    logic [WIDTH-1:0] a_q, b_q, a_d, b_d;

    assign op       = op_e'(bus.cmd_op);
    assign cmd_fire = bus.cmd_valid && (state_q == ST_IDLE);

    swap_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .state_i    (state_q),
        .cmd_fire_i (cmd_fire),
        .op_i       (op),
        .data_i     (bus.cmd_data),
        .a_q_o      (a_q),
        .b_q_o      (b_q),
        .a_d_o      (a_d),
        .b_d_o      (b_d)
    );

    // Response data is captured from the datapath next-values on the edge
    // that enters RESP, so it reflects the command's final A/B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (op == OP_SWAP) begin
                            state_q <= ST_SW1;
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_a_q     <= a_d;
                            rsp_b_q     <= b_d;
                        end
                    end
                end
                ST_SW1: state_q <= ST_SW2;
`ifdef SWAP_XOR_EN
                ST_SW2: state_q <= ST_SW3;
                ST_SW3: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_a_q     <= a_d;
                    rsp_b_q     <= b_d;
                end
`else
                ST_SW2: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_a_q     <= a_d;
                    rsp_b_q     <= b_d;
                end
`endif
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_a     = rsp_a_q;
    assign bus.rsp_b     = rsp_b_q;
    assign busy          = (state_q != ST_IDLE);

    // a_q/b_q are observed only through the response path.
    logic unused_ok;
    assign unused_ok = ^{a_q, b_q};
endmodule

// File: tb/tb_reg_exchange_unit.sv
module tb_reg_exchange_unit;
    import reg_exchange_pkg::*;

    localparam int W = 32;
`ifdef SWAP_XOR_EN
    localparam int SWAP_LAT = 4;
`else
    localparam int SWAP_LAT = 3;
`endif

    logic clk;
    logic rst_n;
    logic busy;

    reg_exchange_unit_if #(.WIDTH(W)) bus ();

    reg_exchange_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] m_a, m_b;
    int           checks = 0;
    int           errors = 0;

    // Reference model: push expected response when a command is issued.
    task automatic model_push(input logic [1:0] op, input logic [W-1:0] data);
        exp_t e;
        logic [W-1:0] t;
        case (op)
            2'b00: m_a = data;
            2'b01: m_b = data;
            2'b10: begin t = m_a; m_a = m_b; m_b = t; end
            default: ;
        endcase
        e.a = m_a;
        e.b = m_b;
        e.lat = (op == 2'b10) ? SWAP_LAT : 1;
        sb_q.push_back(e);
    endtask

    // Drives one command starting #1 after a rising edge; returns the cycle
    // count to first rsp_valid and the sampled response. Does not handshake.
    task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] data,
                            output int lat, output logic [W-1:0] ra,
                            output logic [W-1:0] rb);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        ra = bus.rsp_a;
        rb = bus.rsp_b;
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int lat;
        logic [W-1:0] ra, rb;
        exp_t e;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0 ||
                bus.rsp_a !== '0 || bus.rsp_b !== '0) begin
                errors++;
                $display("FAIL reset_outputs: cmd_ready=%b rsp_valid=%b busy=%b rsp_a=%h rsp_b=%h, need 1 0 0 0 0",
                         bus.cmd_ready, bus.rsp_valid, busy, bus.rsp_a, bus.rsp_b);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_push(2'b11, '0);
        send_cmd(2'b11, 32'h1234_5678, lat, ra, rb);
        e = sb_q.pop_front();
        checks++;
        if (ra !== e.a || rb !== e.b || lat !== e.lat) begin
            errors++;
            $display("FAIL reset_read: a=%h b=%h lat=%0d, need a=%h b=%h lat=%0d", ra, rb, lat, e.a, e.b, e.lat);
        end
        handshake();
    endtask

    task automatic test_load_swap();
        logic [1:0]   ops[3]   = '{2'b00, 2'b01, 2'b10};
        logic [W-1:0] datas[3] = '{32'd5, 32'd10, 32'd0};
        int lat;
        logic [W-1:0] ra, rb;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            model_push(ops[i], datas[i]);
            send_cmd(ops[i], datas[i], lat, ra, rb);
            e = sb_q.pop_front();
            checks++;
            if (ra !== e.a || rb !== e.b || lat !== e.lat) begin
                errors++;
                $display("FAIL load_swap[%0d]: a=%h b=%h lat=%0d, need a=%h b=%h lat=%0d",
                         i, ra, rb, lat, e.a, e.b, e.lat);
            end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]   ops[5]   = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b11};
        logic [W-1:0] datas[5] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        int lat;
        logic [W-1:0] ra, rb;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: cmd_ready=%b, need 1", i, bus.cmd_ready);
            end
            model_push(ops[i], datas[i]);
            send_cmd(ops[i], datas[i], lat, ra, rb);
            e = sb_q.pop_front();
            checks++;
            if (ra !== e.a || rb !== e.b || lat !== e.lat) begin
                errors++;
                $display("FAIL b2b[%0d]: a=%h b=%h lat=%0d, need a=%h b=%h lat=%0d",
                         i, ra, rb, lat, e.a, e.b, e.lat);
            end
            handshake();
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [W-1:0] ra, rb;
        exp_t e;
        model_push(2'b00, 32'hA5A5_0001);
        send_cmd(2'b00, 32'hA5A5_0001, lat, ra, rb);
        e = sb_q.pop_front();
        handshake();
        model_push(2'b10, '0);
        bus.rsp_ready = 1'b0;
        send_cmd(2'b10, '0, lat, ra, rb);
        e = sb_q.pop_front();
        checks++;
        if (ra !== e.a || rb !== e.b || lat !== e.lat) begin
            errors++;
            $display("FAIL stall_swap: a=%h b=%h lat=%0d, need a=%h b=%h lat=%0d", ra, rb, lat, e.a, e.b, e.lat);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 32'h7777_7777;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || busy !== 1'b1 ||
                bus.rsp_a !== e.a || bus.rsp_b !== e.b) begin
                errors++;
                $display("FAIL stall_hold[%0d]: rsp_valid=%b cmd_ready=%b busy=%b a=%h b=%h, need 1 0 1 a=%h b=%h",
                         i, bus.rsp_valid, bus.cmd_ready, busy, bus.rsp_a, bus.rsp_b, e.a, e.b);
            end
        end
        bus.cmd_valid = 1'b0;
        handshake();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: rsp_valid=%b cmd_ready=%b busy=%b, need 0 1 0",
                     bus.rsp_valid, bus.cmd_ready, busy);
        end
        model_push(2'b11, '0);
        send_cmd(2'b11, '0, lat, ra, rb);
        e = sb_q.pop_front();
        checks++;
        if (ra !== e.a || rb !== e.b) begin
            errors++;
            $display("FAIL stall_ignored_cmd: a=%h b=%h, need a=%h b=%h", ra, rb, e.a, e.b);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [W-1:0] ra, rb;
        exp_t e;
        model_push(2'b00, 32'd7); send_cmd(2'b00, 32'd7, lat, ra, rb); e = sb_q.pop_front(); handshake();
        model_push(2'b01, 32'd9); send_cmd(2'b01, 32'd9, lat, ra, rb); e = sb_q.pop_front(); handshake();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_swap_busy: busy=%b cmd_ready=%b, need 1 0", busy, bus.cmd_ready);
        end
        rst_n = 1'b0;
        m_a = '0;
        m_b = '0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: rsp_valid=%b busy=%b cmd_ready=%b, need 0 0 1",
                     bus.rsp_valid, busy, bus.cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_push(2'b11, '0);
        send_cmd(2'b11, '0, lat, ra, rb);
        e = sb_q.pop_front();
        checks++;
        if (ra !== e.a || rb !== e.b || lat !== e.lat) begin
            errors++;
            $display("FAIL mid_reset_read: a=%h b=%h lat=%0d, need a=%h b=%h lat=%0d", ra, rb, lat, e.a, e.b, e.lat);
        end
        handshake();
    endtask

    task automatic test_data_ignored();
        logic [1:0]   ops[4]   = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [W-1:0] datas[4] = '{32'h0000_0001, 32'h8000_0002, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        int lat;
        logic [W-1:0] ra, rb;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            // Model ignores data for SWAP/READ by construction.
            model_push(ops[i], datas[i]);
            send_cmd(ops[i], datas[i], lat, ra, rb);
            e = sb_q.pop_front();
            checks++;
            if (ra !== e.a || rb !== e.b || lat !== e.lat) begin
                errors++;
                $display("FAIL data_ignored[%0d]: a=%h b=%h lat=%0d, need a=%h b=%h lat=%0d",
                         i, ra, rb, lat, e.a, e.b, e.lat);
            end
            handshake();
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b1;
        m_a = '0;
        m_b = '0;
        test_reset();
        test_load_swap();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_data_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/reg_exchange_unit.md
# reg_exchange_unit

Command-driven two-register exchange engine: a requester loads operands A and B, issues SWAP or READ commands over a valid/ready command channel, and receives the register contents on a valid/ready response channel. It sits in the Chapter 7 datapath examples as the responder side of the swap operation: it executes the exchange as a multi-cycle, hazard-free sequence and reports the result. Every accepted command produces exactly one response.

## Interface
- WIDTH, 32, data width of A, B and all data ports
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 LOAD_A, 01 LOAD_B, 10 SWAP, 11 READ
- cmd_data  in  WIDTH  operand for LOAD_A/LOAD_B; ignored otherwise
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_a  out  WIDTH  value of A after the command
- rsp_b  out  WIDTH  value of B after the command
- busy  out  1  state != IDLE

## Operation
- One clock; reset is asynchronous and active-low.
- FSM states: IDLE, SW1, SW2, SW3 (macro-only), RESP.
- IDLE: cmd_ready=1. Accept when cmd_valid && cmd_ready at a rising edge.
  - LOAD_A: A <= cmd_data; -> RESP. LOAD_B: B <= cmd_data; -> RESP.
  - READ: -> RESP, no register change. SWAP: -> SW1.
- Default swap (temp registers): SW1 temp_a <= A, temp_b <= B; SW2 A <= temp_b, B <= temp_a; -> RESP.
- Entering RESP: rsp_a/rsp_b registered from the post-command A/B values; held stable while in RESP.
- RESP: rsp_valid=1; on rsp_ready -> IDLE. rsp_valid stays high until that handshake.
- cmd_ready=0 in every state except IDLE, so there is no overlap of commands and no new command is accepted in the same cycle as a response handshake.
- cmd_ready is combinational from state; rsp_valid, rsp_a, rsp_b, busy are registered or derived from state only. There are no combinational paths from input to output.

## Timing
- Reset values: A=B=temp_a=temp_b=0, state IDLE, rsp_valid=0, rsp_a=rsp_b=0, busy=0, cmd_ready=1.
- Latency (accept edge to first rsp_valid=1 cycle): LOAD/READ 1 cycle; SWAP 3 cycles (4 with SWAP_XOR_EN).
- Minimum command-to-command spacing: latency + 1 cycle (response handshake cycle).
- rsp_ready held low: the FSM stalls in RESP, and the outputs are frozen.
- Reset asserted mid-sequence (any of SW1..RESP): immediate return to IDLE. Registers are cleared and the pending response is discarded.
- Width: all transfers are full WIDTH, with no truncation or extension.

## Configuration
- SWAP_XOR_EN defined: the temp registers are removed. SWAP runs as SW1 A <= A^B; SW2 B <= A^B; SW3 A <= A^B; -> RESP. The result is identical to the default, including when A==B.
- Undefined: the temp-register sequence (SW1, SW2) is used and SW3 does not exist.

## Structure
- Package reg_exchange_pkg: cmd_op encoding enum (OP_LOAD_A, OP_LOAD_B, OP_SWAP, OP_READ), FSM state enum, default WIDTH constant.
- Sub-module swap_datapath: holds A, B, temps and the per-state update controls from the FSM. The top level keeps the FSM and both handshakes.

## Test plan
- After reset, READ -> rsp_a=0, rsp_b=0, 1-cycle latency, cmd_ready=1 throughout reset.
- LOAD_A 5, LOAD_B 10, SWAP -> response a=10, b=5, exactly 3 cycles after acceptance (4 with macro).
- Second SWAP immediately after the handshake -> a=5, b=10; A=B=32'hFFFF_FFFF SWAP -> both unchanged.
- rsp_ready low for 4 cycles after SWAP -> rsp_valid held, values stable, cmd_ready=0, cmd_valid ignored.
- rst_n pulsed low during SW2 -> A=B=0, rsp_valid=0, busy=0 immediately; subsequent READ -> 0,0.
- cmd_valid with cmd_op=SWAP and cmd_data=32'hDEAD_BEEF -> cmd_data ignored, only the swap occurs.
